bus_transfer_sequencer: RTL



---
 rtl/bus_transfer_sequencer_pkg.sv | 66 ++++++
 rtl/bus_transfer_sequencer_if.sv | 42 ++++
 rtl/bus_transfer_sequencer_code_to_onehot_27.sv | 25 ++
 rtl/bus_transfer_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bus_transfer_sequencer_pkg.sv
// rtl/bus_transfer_sequencer_pkg.sv - shared codes, state type and code validation for the bus transfer sequencer
//
// Contents:
//   NUM_SEL        number of bus endpoints (one-hot vector width)
//   CODE_W         width of a source/destination code
//   CODE_*         5-bit endpoint codes in bus encoder order
//   state_t        sequencer FSM states
//   is_valid_src   code names an existing bus source
//   is_valid_dst   code names an existing, bus-loadable destination

package bus_transfer_sequencer_pkg;

    localparam int NUM_SEL = 27;
    localparam int CODE_W  = 5;

    localparam logic [CODE_W-1:0] CODE_R0     = 5'd0;
    localparam logic [CODE_W-1:0] CODE_R1     = 5'd1;
    localparam logic [CODE_W-1:0] CODE_R2     = 5'd2;
    localparam logic [CODE_W-1:0] CODE_R3     = 5'd3;
    localparam logic [CODE_W-1:0] CODE_R4     = 5'd4;
    localparam logic [CODE_W-1:0] CODE_R5     = 5'd5;
    localparam logic [CODE_W-1:0] CODE_R6     = 5'd6;
    localparam logic [CODE_W-1:0] CODE_R7     = 5'd7;
    localparam logic [CODE_W-1:0] CODE_R8     = 5'd8;
    localparam logic [CODE_W-1:0] CODE_R9     = 5'd9;
    localparam logic [CODE_W-1:0] CODE_R10    = 5'd10;
    localparam logic [CODE_W-1:0] CODE_R11    = 5'd11;
    localparam logic [CODE_W-1:0] CODE_R12    = 5'd12;
    localparam logic [CODE_W-1:0] CODE_R13    = 5'd13;
    localparam logic [CODE_W-1:0] CODE_R14    = 5'd14;
    localparam logic [CODE_W-1:0] CODE_R15    = 5'd15;
    localparam logic [CODE_W-1:0] CODE_HI     = 5'd16;
    localparam logic [CODE_W-1:0] CODE_LO     = 5'd17;
    localparam logic [CODE_W-1:0] CODE_ZHI    = 5'd18;
    localparam logic [CODE_W-1:0] CODE_ZLO    = 5'd19;
    localparam logic [CODE_W-1:0] CODE_PC     = 5'd20;
    localparam logic [CODE_W-1:0] CODE_MDR    = 5'd21;
    localparam logic [CODE_W-1:0] CODE_INPORT = 5'd22;
    localparam logic [CODE_W-1:0] CODE_C      = 5'd23;
    localparam logic [CODE_W-1:0] CODE_Y      = 5'd24;
    localparam logic [CODE_W-1:0] CODE_IR     = 5'd25;
    localparam logic [CODE_W-1:0] CODE_MAR    = 5'd26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Every endpoint up to MAR can drive the bus.
    function automatic logic is_valid_src(input logic [CODE_W-1:0] code);
        return (code <= CODE_MAR);
    endfunction

    // ZHI/ZLO, InPort and C only ever drive the bus; they have no load enable.
    function automatic logic is_valid_dst(input logic [CODE_W-1:0] code);
        logic ok;
        case (code)
            CODE_ZHI, CODE_ZLO, CODE_INPORT, CODE_C: ok = 1'b0;
            default:                                 ok = (code <= CODE_MAR);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// rtl/bus_transfer_sequencer_if.sv - transfer request, bus data and enable/handshake bundle
//
// Signals:
//   start       transfer request from the control unit
//   src_code    bus source code
//   dst_code    destination code
//   bus_in      BusMuxOut word
//   src_out     one-hot out-enables to the bus encoder
//   dst_in      one-hot load-enables to the registers
//   busy        transfer in progress
//   done        one-cycle completion pulse
//   error       one-cycle rejection pulse
//   last_value  word captured on the load cycle
// Modports:
//   master      control unit / bus side
//   slave       sequencer side

interface bus_transfer_sequencer_if;
    import bus_transfer_sequencer_pkg::*;

    logic                 start;
    logic [CODE_W-1:0]    src_code;
    logic [CODE_W-1:0]    dst_code;
    logic [31:0]          bus_in;
    logic [NUM_SEL-1:0]   src_out;
    logic [NUM_SEL-1:0]   dst_in;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [31:0]          last_value;

    modport master (
        output start, src_code, dst_code, bus_in,
        input  src_out, dst_in, busy, done, error, last_value
    );

    modport slave (
        input  start, src_code, dst_code, bus_in,
        output src_out, dst_in, busy, done, error, last_value
    );

endinterface

// File: rtl/bus_transfer_sequencer_code_to_onehot_27.sv
// rtl/bus_transfer_sequencer_code_to_onehot_27.sv - 5-bit endpoint code to one-hot enable decoder
//
// Ports:
//   i_code    endpoint code (encoder order)
//   o_onehot  one-hot enable; all zero for codes with no endpoint

module code_to_onehot_27 #(
    parameter int NUM_SEL = 27
) (
    input  logic [4:0]         i_code,
    output logic [NUM_SEL-1:0] o_onehot
);

    // Inverse of the bus encoder: out-of-range codes select nothing,
    // so the result is always zero or one-hot.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (i_code == 5'(i)) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// rtl/bus_transfer_sequencer.sv - register-transfer sequencer: drive source, settle, pulse destination load
//
// Parameters:
//   SETTLE_CYCLES  cycles src_out is held before the load cycle (1..15)
//   NUM_SEL        number of bus endpoints
// Ports:
//   clk    system clock, rising edge
//   clr    synchronous active-low reset
//   xfer   slave side of bus_transfer_sequencer_if (request, bus word,
//          enables, busy/done/error, captured word)

module bus_transfer_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_SEL       = bus_transfer_sequencer_pkg::NUM_SEL
) (
    input  logic                      clk,
    input  logic                      clr,
    bus_transfer_sequencer_if.slave   xfer
);
    import bus_transfer_sequencer_pkg::*;

    localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nxt;
    logic [CODE_W-1:0]    r_src_q;
    logic [CODE_W-1:0]    r_dst_q;
    logic                 w_accept;
    logic                 w_error_nxt;
    logic [CODE_W-1:0]    w_src_sel;
    logic [NUM_SEL-1:0]   w_src_onehot;
    logic [NUM_SEL-1:0]   w_dst_onehot;
    logic [NUM_SEL-1:0]   w_src_out_nxt;
    logic [NUM_SEL-1:0]   w_dst_in_nxt;
    logic [NUM_SEL-1:0]   r_src_out;
    logic [NUM_SEL-1:0]   r_dst_in;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [31:0]          r_last_value;

    // Outputs are registered, so the enable for the first DRIVE cycle is
    // decoded from the incoming request while still in IDLE; after that
    // the latched code is used.
    assign w_src_sel = (r_state == ST_IDLE) ? xfer.src_code : r_src_q;

    code_to_onehot_27 #(.NUM_SEL(NUM_SEL)) u_src_dec (
        .i_code   (w_src_sel),
        .o_onehot (w_src_onehot)
    );

    code_to_onehot_27 #(.NUM_SEL(NUM_SEL)) u_dst_dec (
        .i_code   (r_dst_q),
        .o_onehot (w_dst_onehot)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_accept      = 1'b0;
        w_error_nxt   = 1'b0;
        w_src_out_nxt = '0;
        w_dst_in_nxt  = '0;

        case (r_state)
            ST_IDLE: begin
                if (xfer.start) begin
                    if (is_valid_src(xfer.src_code) && is_valid_dst(xfer.dst_code)) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_DRIVE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Enables are a function of the state being entered, which keeps
        // dst_in confined to the single LOAD cycle.
        if ((w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_LOAD)) begin
            w_src_out_nxt = w_src_onehot;
        end
        if (w_state_nxt == ST_LOAD) begin
            w_dst_in_nxt = w_dst_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_src_q      <= '0;
            r_dst_q      <= '0;
            r_src_out    <= '0;
            r_dst_in     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_last_value <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_accept) begin
                r_src_q <= xfer.src_code;
                r_dst_q <= xfer.dst_code;
            end
            r_src_out <= w_src_out_nxt;
            r_dst_in  <= w_dst_in_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
            r_error   <= w_error_nxt;
            // The destination loads at the end of LOAD; mirror that word.
            if (r_state == ST_LOAD) begin
                r_last_value <= xfer.bus_in;
            end
        end
    end

    assign xfer.src_out    = r_src_out;
    assign xfer.dst_in     = r_dst_in;
    assign xfer.busy       = r_busy;
    assign xfer.done       = r_done;
    assign xfer.error      = r_error;
    assign xfer.last_value = r_last_value;

endmodule
